// File: rtl/out_channel_monitor_if.sv
// out_channel_monitor_if: valid/ready word channel carrying `out` words
// from the program engine to the out-channel monitor.
interface out_channel_monitor_if #(
    parameter int W = 12
);
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/out_channel_monitor.sv
// out_channel_monitor: captures program out words, checks them against a table.
// Define OUT_CHANNEL_MONITOR_READBACK_EN to add the rd_addr/rd_data read port.
module out_channel_monitor #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 8,
    parameter int MaxSteps           = 1024,
    parameter int StepWidth          = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          expect_we,
    input  logic [$clog2(NOut)-1:0]       expect_addr,
    input  logic [MemoryElementWidth-1:0] expect_data,
    input  logic [$clog2(NOut):0]         expect_count,
    out_channel_monitor_if.slave          out_ch,
    output logic [$clog2(NOut):0]         received,
    output logic [$clog2(NOut):0]         mismatch_index,
    output logic                          finished,
    output logic                          success
`ifdef OUT_CHANNEL_MONITOR_READBACK_EN
    ,
    input  logic [$clog2(NOut)-1:0]       rd_addr,
    output logic [MemoryElementWidth-1:0] rd_data
`endif
);

    localparam int AW = $clog2(NOut);
    localparam int CW = AW + 1;
    localparam int W  = MemoryElementWidth;

    localparam logic [CW-1:0]        NONE   = '1;
    localparam logic [CW-1:0]        NOUT_C = CW'(NOut);
    localparam logic [StepWidth-1:0] MAX_C  = StepWidth'(MaxSteps);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        recv_q, recv_d;
    logic [CW-1:0]        mis_q, mis_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [StepWidth-1:0] step_q, step_d;
    logic                 fin_q, fin_d;
    logic                 succ_q, succ_d;
    logic [W-1:0]         exp_q [NOut];

    logic                 ready;
    logic                 xfer;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_LOAD;
            recv_q  <= '0;
            mis_q   <= NONE;
            cnt_q   <= '0;
            step_q  <= '0;
            fin_q   <= 1'b0;
            succ_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            recv_q  <= recv_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            fin_q   <= fin_d;
            succ_q  <= succ_d;
        end
    end

    // Table keeps its contents across reset; only LOAD may change it.
    always_ff @(posedge clock) begin
        if (state_q == S_LOAD && expect_we) begin
            exp_q[expect_addr] <= expect_data;
        end
    end

    always_comb begin
        state_d = state_q;
        recv_d  = recv_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        fin_d   = fin_q;
        succ_d  = succ_q;
        ready   = 1'b0;
        xfer    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = expect_count;
                    step_d  = '0;
                end
            end
            S_RUN: begin
                ready  = (recv_q < NOUT_C);
                xfer   = out_ch.out_valid && ready;
                step_d = step_q + 1'b1;
                if (xfer) begin
                    if (out_ch.out_data != exp_q[recv_q[AW-1:0]]
                        && mis_q == NONE) begin
                        mis_d = recv_q;
                    end
                    recv_d = recv_q + 1'b1;
                end
                // Exits use post-transfer values, extra word first.
                if (xfer && recv_d > cnt_q) begin
                    state_d = S_DONE;
                    fin_d   = 1'b1;
                    succ_d  = 1'b0;
                end else if (recv_d == cnt_q) begin
                    state_d = S_DONE;
                    fin_d   = 1'b1;
                    succ_d  = (mis_d == NONE);
                end else if (step_d == MAX_C) begin
                    state_d = S_DONE;
                    fin_d   = 1'b1;
                    succ_d  = 1'b0;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign out_ch.out_ready = ready;
    assign received         = recv_q;
    assign mismatch_index   = mis_q;
    assign finished         = fin_q;
    assign success          = succ_q;

`ifdef OUT_CHANNEL_MONITOR_READBACK_EN
    logic [W-1:0] cap_q [NOut];
    logic [W-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (xfer) begin
            cap_q[recv_q[AW-1:0]] <= out_ch.out_data;
        end
        rd_q <= cap_q[rd_addr];
    end

    assign rd_data = rd_q;
`endif

endmodule
